// File: rtl/c2sif_arb.sv
// c2sif_arb: round-robin arbiter/sequencer sharing one register bus between
// N_REQ c2sif scenario masters. A granted master's packet (fn/addr/wdata) is
// latched, executed as a DATA_SIZE-beat write or read burst on the bus, and
// answered with rsp_ret/rsp_rdata under a four-phase req/ack handshake.
//
// Ports:
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   req / ack         per-master request level / acknowledge level (one-hot)
//   req_fn            per-master function, 0 = DATA_WRITE, 1 = DATA_READ
//   req_addr          per-master start byte address
//   req_wdata         per-master write words, word 0 in the LSBs
//   rsp_rdata         read words returned to the acked master
//   rsp_ret           0 ok, FFFF_FFFF bad fn, FFFF_FFFE bus timeout
//   gnt_idx, busy     granted master index, high from grant until release
//   bus_valid/we/addr/wdata, bus_ready/rdata   register bus master port
module c2sif_arb #(
    parameter int N_REQ     = 2,
    parameter int DATA_SIZE = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req,
    output logic [N_REQ-1:0]              ack,
    input  logic [N_REQ*32-1:0]           req_fn,
    input  logic [N_REQ*32-1:0]           req_addr,
    input  logic [N_REQ*DATA_SIZE*32-1:0] req_wdata,
    output logic [DATA_SIZE*32-1:0]       rsp_rdata,
    output logic [31:0]                   rsp_ret,
    output logic [2:0]                    gnt_idx,
    output logic                          busy,
    output logic                          bus_valid,
    output logic                          bus_we,
    output logic [31:0]                   bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic                          bus_ready,
    input  logic [31:0]                   bus_rdata
);

    localparam int          BW        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int          WW        = DATA_SIZE * 32;
    localparam logic [7:0]  TLIM      = 8'(TIMEOUT - 1);
    localparam logic [31:0] RET_OK    = 32'h0000_0000;
    localparam logic [31:0] RET_BADFN = 32'hFFFF_FFFF;
    localparam logic [31:0] RET_TMO   = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {IDLE, ARB, XFER, ACK, REL} state_t;

    state_t          state, state_d;
    logic [2:0]      ptr;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   beat_inc;
    logic [7:0]      tcnt;
    logic [WW-1:0]   wdata_q;

    logic            found;
    logic [2:0]      pick;
    logic [2:0]      ptr_nxt;
    logic [3:0]      cand;
    logic [31:0]     sel_fn;
    logic [31:0]     sel_addr;
    logic [WW-1:0]   sel_wdata;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] gnt_oh;
    logic            req_gnt;
    logic            fn_ok;
    logic            last_beat;
    logic [31:0]     next_word;

    // First requester at or after the pointer, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (cand == 4'(i))) begin
                    found = 1'b1;
                    pick  = 3'(i);
                end
            end
        end
    end

    assign ptr_nxt = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;

    always_comb begin
        sel_fn    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        pick_oh   = '0;
        gnt_oh    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == 3'(i)) begin
                sel_fn     = req_fn[i*32 +: 32];
                sel_addr   = req_addr[i*32 +: 32];
                sel_wdata  = req_wdata[i*WW +: WW];
                pick_oh[i] = 1'b1;
            end
            if (gnt_idx == 3'(i)) gnt_oh[i] = 1'b1;
        end
    end

    assign req_gnt   = |(req & gnt_oh);
    assign fn_ok     = (sel_fn[31:1] == 31'd0);
    assign last_beat = (beat == BW'(DATA_SIZE - 1));
    assign beat_inc  = beat + BW'(1);

    always_comb begin
        next_word = '0;
        for (int j = 0; j < DATA_SIZE; j++) begin
            if (beat_inc == BW'(j)) next_word = wdata_q[j*32 +: 32];
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (|req) state_d = ARB;
            ARB: begin
                if (!found)     state_d = IDLE;
                else if (fn_ok) state_d = XFER;
                else            state_d = ACK;
            end
            XFER: begin
                if (bus_ready) begin
                    if (last_beat) state_d = ACK;
                end else if (tcnt == TLIM) begin
                    state_d = ACK;
                end
            end
            ACK:     if (!req_gnt) state_d = REL;
            REL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            rsp_rdata <= '0;
            rsp_ret   <= '0;
            gnt_idx   <= '0;
            busy      <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            ptr       <= '0;
            beat      <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                ARB: if (found) begin
                    gnt_idx   <= pick;
                    busy      <= 1'b1;
                    beat      <= '0;
                    tcnt      <= '0;
                    rsp_rdata <= '0;
                    ptr       <= ptr_nxt;
                    if (fn_ok) begin
                        bus_valid <= 1'b1;
                        bus_we    <= (sel_fn == 32'd0);
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata[31:0];
                    end else begin
                        rsp_ret <= RET_BADFN;
                        ack     <= pick_oh;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        for (int j = 0; j < DATA_SIZE; j++) begin
                            if (!bus_we && (beat == BW'(j))) rsp_rdata[j*32 +: 32] <= bus_rdata;
                        end
                        tcnt <= '0;
                        if (last_beat) begin
                            bus_valid <= 1'b0;
                            rsp_ret   <= RET_OK;
                            ack       <= gnt_oh;
                        end else begin
                            beat      <= beat_inc;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wdata <= next_word;
                        end
                    end else if (tcnt == TLIM) begin
                        // Abort: completed read beats stay in rsp_rdata.
                        bus_valid <= 1'b0;
                        rsp_ret   <= RET_TMO;
                        ack       <= gnt_oh;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ACK:     if (!req_gnt) ack <= '0;
                REL:     busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // Packet write words are pure data; only captured at grant.
    always_ff @(posedge clk) begin
        if (state == ARB && found) wdata_q <= sel_wdata;
    end

endmodule

// File: tb/tb_c2sif_arb.sv
module tb_c2sif_arb;

    localparam int N_REQ     = 2;
    localparam int DATA_SIZE = 4;
    localparam int TIMEOUT   = 255;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [N_REQ-1:0]              req;
    logic [N_REQ-1:0]              ack;
    logic [N_REQ*32-1:0]           req_fn;
    logic [N_REQ*32-1:0]           req_addr;
    logic [N_REQ*DATA_SIZE*32-1:0] req_wdata;
    logic [DATA_SIZE*32-1:0]       rsp_rdata;
    logic [31:0]                   rsp_ret;
    logic [2:0]                    gnt_idx;
    logic                          busy;
    logic                          bus_valid;
    logic                          bus_we;
    logic [31:0]                   bus_addr;
    logic [31:0]                   bus_wdata;
    logic                          bus_ready;
    logic [31:0]                   bus_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic stayed;

    localparam logic [127:0] RD_EXP = {32'h2A9, 32'h2AD, 32'h2A1, 32'h2A5};

    c2sif_arb #(.N_REQ(N_REQ), .DATA_SIZE(DATA_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .req_fn    (req_fn),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_rdata (rsp_rdata),
        .rsp_ret   (rsp_ret),
        .gnt_idx   (gnt_idx),
        .busy      (busy),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus slave read data model.
    assign bus_rdata = bus_addr ^ 32'h0000_00A5;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_fn    = '0;
        req_addr  = '0;
        req_wdata = '0;
        bus_ready = 1'b0;
        tick;
        tick;
        // Reset state
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus_valid, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_ret", rsp_ret, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_gnt", gnt_idx, 0);
        rst_n = 1'b1;
        tick;

        // Single write from m0, bus always ready
        req_fn[31:0]     = 32'd0;
        req_addr[31:0]   = 32'h100;
        req_wdata[127:0] = {32'd4, 32'd3, 32'd2, 32'd1};
        bus_ready        = 1'b1;
        req[0]           = 1'b1;
        tick;
        chk("w_arb_novalid", bus_valid, 0);
        tick;
        chk("w_busy", busy, 1);
        chk("w_gnt", gnt_idx, 0);
        chk("w_we", bus_we, 1);
        for (int b = 0; b < 4; b++) begin
            chk("w_valid", bus_valid, 1);
            chk("w_addr", bus_addr, 32'(32'h100 + 4 * b));
            chk("w_data", bus_wdata, 32'(b + 1));
            tick;
        end
        chk("w_ack", ack, 2'b01);
        chk("w_ret", rsp_ret, 0);
        chk("w_valid_off", bus_valid, 0);
        tick;
        chk("w_ack_hold", ack, 2'b01);
        req[0] = 1'b0;
        tick;
        chk("w_ack_fall", ack, 0);
        chk("w_busy_rel", busy, 1);
        tick;
        chk("w_idle", busy, 0);

        // Read from m1 with ready every second cycle
        req_fn[63:32]   = 32'd1;
        req_addr[63:32] = 32'h200;
        bus_ready       = 1'b0;
        req[1]          = 1'b1;
        tick;
        tick;
        chk("r_gnt", gnt_idx, 1);
        chk("r_we", bus_we, 0);
        chk("r_valid", bus_valid, 1);
        for (int b = 0; b < 4; b++) begin
            bus_ready = 1'b0;
            chk("r_addr_wait", bus_addr, 32'(32'h200 + 4 * b));
            tick;
            bus_ready = 1'b1;
            chk("r_addr_rdy", bus_addr, 32'(32'h200 + 4 * b));
            tick;
        end
        bus_ready = 1'b0;
        chk("r_ack", ack, 2'b10);
        chk("r_rdata", rsp_rdata, RD_EXP);
        chk("r_ret", rsp_ret, 0);
        chk("r_valid_off", bus_valid, 0);
        req[1] = 1'b0;
        tick;
        chk("r_ack_fall", ack, 0);
        tick;
        chk("r_idle", busy, 0);

        // Round-robin with both masters requesting every pass
        req_fn          = '0;
        req_addr[31:0]  = 32'h300;
        req_addr[63:32] = 32'h400;
        bus_ready       = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req = 2'b11;
            tick;
            tick;
            chk("rr_gnt", gnt_idx, 3'(r % 2));
            chk("rr_addr", bus_addr, (r % 2 == 1) ? 32'h400 : 32'h300);
            repeat (4) tick;
            chk("rr_ack", ack, (r % 2 == 1) ? 2'b10 : 2'b01);
            req[r % 2] = 1'b0;
            tick;
            chk("rr_ack_fall", ack, 0);
            tick;
        end
        req = '0;
        tick;

        // Bad function code
        req_fn[31:0] = 32'd7;
        req[0]       = 1'b1;
        tick;
        chk("bf_ack_early", ack, 0);
        tick;
        chk("bf_ack", ack, 2'b01);
        chk("bf_ret", rsp_ret, 32'hFFFF_FFFF);
        chk("bf_novalid", bus_valid, 0);
        chk("bf_busy", busy, 1);
        req[0] = 1'b0;
        tick;
        chk("bf_ack_fall", ack, 0);
        tick;
        chk("bf_idle", busy, 0);

        // Timeout with bus_ready stuck low
        req_fn[31:0]   = 32'd0;
        req_addr[31:0] = 32'h500;
        bus_ready      = 1'b0;
        req[0]         = 1'b1;
        tick;
        tick;
        chk("to_valid", bus_valid, 1);
        stayed = 1'b1;
        repeat (254) begin
            tick;
            if (!bus_valid) stayed = 1'b0;
        end
        chk("to_hold", stayed, 1);
        tick;
        chk("to_drop", bus_valid, 0);
        chk("to_ret", rsp_ret, 32'hFFFF_FFFE);
        chk("to_ack", ack, 2'b01);
        chk("to_rdata", rsp_rdata, 0);
        req[0] = 1'b0;
        tick;
        tick;

        // Async reset during beat 2 of a write
        req_addr[31:0] = 32'h100;
        bus_ready      = 1'b1;
        req[0]         = 1'b1;
        tick;
        tick;
        tick;
        tick;
        chk("ar_beat2", bus_addr, 32'h108);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_valid", bus_valid, 0);
        chk("ar_ack", ack, 0);
        req = '0;
        tick;
        rst_n = 1'b1;
        tick;
        req_fn[63:32]   = 32'd1;
        req_addr[63:32] = 32'h200;
        req[1]          = 1'b1;
        tick;
        tick;
        chk("ar_gnt", gnt_idx, 1);
        repeat (4) tick;
        chk("ar_ack1", ack, 2'b10);
        chk("ar_rdata", rsp_rdata, RD_EXP);
        chk("ar_ret", rsp_ret, 0);
        req[1] = 1'b0;
        tick;
        chk("ar_ack_fall", ack, 0);
        tick;
        chk("ar_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/c2sif_arb.md
Name: c2sif_arb

Overview:
Round-robin arbiter and sequencer that shares one clocked register bus between N_REQ c2sif scenario masters. Each master uses the four-phase req/ack packet handshake with fn/addr/data. The block grants one master and executes its write or read burst of DATA_SIZE 32-bit beats on the bus. It then returns ret and read data, acks, and releases the master. It sits between the c2sif interface instances and the DUT register/memory port.

Parameters:
N_REQ, 2, number of c2sif masters (1..8)
DATA_SIZE, 4, beats per packet (matches C2SIF_DATA_SIZE)
TIMEOUT, 255, max cycles waiting for bus_ready per beat before abort (8-bit counter)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-master request level
ack  out  N_REQ  per-master acknowledge level, at most one bit high
req_fn  in  N_REQ*32  per-master function: 0 = DATA_WRITE, 1 = DATA_READ
req_addr  in  N_REQ*32  per-master start byte address
req_wdata  in  N_REQ*DATA_SIZE*32  per-master write words, word 0 in LSBs
rsp_rdata  out  DATA_SIZE*32  read words for the currently acked master
rsp_ret  out  32  result: 0 ok, 32'hFFFF_FFFF bad fn, 32'hFFFF_FFFE timeout
gnt_idx  out  3  index of the granted master, valid when busy
busy  out  1  high from grant until release
bus_valid  out  1  bus transfer request
bus_we  out  1  1 = write
bus_addr  out  32  beat byte address
bus_wdata  out  32  write data
bus_ready  in  1  transfer accepted this cycle
bus_rdata  in  32  read data, valid when bus_valid&bus_ready and !bus_we

Behaviour:
- Reset values: ack=0, rsp_rdata=0, rsp_ret=0, gnt_idx=0, busy=0, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0. Round-robin pointer is 0 (master 0 has highest priority first).
- Reset mid-operation drops ack and bus_valid immediately and discards the packet. Masters see no ack and must re-request.
- FSM states: IDLE, ARB, XFER, ACK, REL.
- IDLE: if any req is high, go to ARB.
- ARB (1 cycle): grant the first requester at or after the pointer, wrapping from N_REQ-1 to 0.
  - Latch that master's fn, addr and wdata, and set gnt_idx.
  - Set busy=1, beat counter=0, rsp_rdata=0.
  - If fn is not 0 or 1: rsp_ret=FFFF_FFFF and go to ACK with no bus activity.
  - Otherwise go to XFER.
  - Pointer = granted index + 1, modulo N_REQ.
- XFER: bus_valid=1, bus_we=(fn==0), bus_addr=addr+4*beat (32-bit wrap), bus_wdata=word[beat].
  - Outputs hold stable until bus_ready.
  - On bus_valid&bus_ready: for a read, store bus_rdata into rsp_rdata word[beat]. Increment beat and clear the timeout counter.
  - After beat DATA_SIZE-1 completes: bus_valid=0, rsp_ret=0, go to ACK. Latency with bus_ready tied high is DATA_SIZE cycles in XFER.
  - If the timeout counter reaches TIMEOUT with no ready: drop bus_valid, rsp_ret=FFFF_FFFE, go to ACK. Beats already completed are kept in rsp_rdata.
- ACK: ack[gnt_idx]=1. Stay in ACK until req[gnt_idx]=0, then ack=0 and go to REL.
  - rsp_ret and rsp_rdata hold stable from ack rise until ack fall.
- REL (1 cycle): busy=0, go to IDLE. Requests already pending are arbitrated on the next pass, so there are no back-to-back grants without the REL gap.
- Other masters' req changes during a transaction are ignored; they are not granted until IDLE.
- A master that drops req before ack: the transaction still completes and ack rises. Because req is already low, the next cycle drops ack and goes to REL.
- A req that is high in IDLE while its ack is still 0 is a new request. A master must not raise req again until it has seen its ack fall.
- N_REQ=1: pointer is always 0.

Test Plan:
- Single write: m0 fn=0, addr=0x100, data {1,2,3,4}, bus_ready=1 → bus writes 0x100..0x10C with 1..4 on 4 consecutive cycles; ack[0] rises with rsp_ret=0; ack falls 1 cycle after req[0] falls.
- Read with wait states: m1 fn=1, addr=0x200, bus_ready high every 2nd cycle, rdata=addr^0xA5 → rsp_rdata = {0x2A5,0x2A1,0x2AD,0x2A9} at ack[1]; each address held stable until its ready.
- Round-robin: m0 and m1 assert req together, repeated 4 times → grant order 0,1,0,1; ack never high on both masters.
- Bad fn: m0 fn=7 → no bus_valid; ack[0] rises 2 cycles after req with rsp_ret=0xFFFFFFFF.
- Timeout: bus_ready stuck 0, TIMEOUT=255 → bus_valid drops after 255 cycles; rsp_ret=0xFFFFFFFE; ack[0] rises.
- Async reset asserted during XFER beat 2 → ack, bus_valid and busy are 0 immediately, before any clock edge; after release, a fresh m1 request completes normally.
